// File: rtl/quad_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : quad_encoder_if
// Description : Avalon-MM quadrature encoder peripheral: sync, glitch filter,
//               4x decode, position counter and windowed velocity.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder_if #(
    parameter int FILTER_LEN     = 4,
    parameter int WINDOW_DEFAULT = 500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        enc_a,
    input  logic        enc_b
);

    localparam logic [0:0]  c_st_init     = 1'b0;
    localparam logic [0:0]  c_st_run      = 1'b1;
    localparam logic [4:0]  c_init_last   = 5'(FILTER_LEN + 1);
    localparam logic [3:0]  c_filt_last   = 4'(FILTER_LEN - 1);
    localparam logic [31:0] c_win_default = 32'(WINDOW_DEFAULT);

    // Channel vectors are packed {A, B}: bit1 = A, bit0 = B.
    logic [1:0]  w_raw;
    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  w_filt;
    logic [1:0]  r_prev;
    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [4:0]  r_init_cnt;
    logic [1:0]  w_delta;
    logic        w_fwd;
    logic        w_rev;
    logic        w_illegal;
    logic [31:0] w_step32;
    logic [16:0] w_acc_wide;
    logic [15:0] w_acc_sum;
    logic [31:0] r_position;
    logic [15:0] r_velocity;
    logic [15:0] r_acc;
    logic [31:0] r_win_len;
    logic [31:0] r_win_cnt;
    logic        r_err;
    logic        r_dir;
    logic        w_wr_pos;
    logic        w_wr_stat;
    logic        w_wr_win;

    assign w_raw = {enc_a, enc_b};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
            r_prev  <= 2'b00;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_prev  <= w_filt;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filter
            logic [3:0] r_cnt;
            logic       r_bit;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= 4'd0;
                    r_bit <= 1'b0;
                end else if (r_state == c_st_init) begin
                    // Track the pins directly so a non-zero idle level is not seen as a step.
                    r_cnt <= 4'd0;
                    r_bit <= r_sync2[gi];
                end else if (r_sync2[gi] == r_bit) begin
                    r_cnt <= 4'd0;
                end else if (r_cnt == c_filt_last) begin
                    r_cnt <= 4'd0;
                    r_bit <= r_sync2[gi];
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
            assign w_filt[gi] = r_bit;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_st_init;
            r_init_cnt <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_init) begin
                r_init_cnt <= r_init_cnt + 5'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_st_init && r_init_cnt == c_init_last) begin
            w_state_nxt = c_st_run;
        end
    end

    function automatic logic [1:0] f_phase(input logic [1:0] ab);
        case (ab)
            2'b00:   f_phase = 2'd0;
            2'b01:   f_phase = 2'd1;
            2'b11:   f_phase = 2'd2;
            default: f_phase = 2'd3;
        endcase
    endfunction

    // Phase difference modulo 4: 1 = forward, 3 = reverse, 2 = both pins moved.
    assign w_delta = f_phase(w_filt) - f_phase(r_prev);

    always_comb begin
        w_fwd     = 1'b0;
        w_rev     = 1'b0;
        w_illegal = 1'b0;
        if (r_state == c_st_run) begin
            case (w_delta)
                2'd1:    w_fwd     = 1'b1;
                2'd3:    w_rev     = 1'b1;
                2'd2:    w_illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_step32   = w_fwd ? 32'd1 : (w_rev ? 32'hFFFF_FFFF : 32'd0);
    assign w_acc_wide = {r_acc[15], r_acc} + w_step32[16:0];
    assign w_acc_sum  = (w_acc_wide[16] != w_acc_wide[15]) ?
                        (w_acc_wide[16] ? 16'h8000 : 16'h7FFF) : w_acc_wide[15:0];

    assign w_wr_pos  = write && (address == 2'd0);
    assign w_wr_stat = write && (address == 2'd2);
    assign w_wr_win  = write && (address == 2'd3) && (writedata != 32'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_position <= 32'd0;
            r_err      <= 1'b0;
            r_dir      <= 1'b0;
        end else begin
            r_position <= w_wr_pos ? writedata : r_position + w_step32;
            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (w_wr_stat && writedata[0]) begin
                r_err <= 1'b0;
            end
            if (w_fwd) begin
                r_dir <= 1'b1;
            end else if (w_rev) begin
                r_dir <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_velocity <= 16'd0;
            r_acc      <= 16'd0;
            r_win_len  <= c_win_default;
            r_win_cnt  <= c_win_default - 32'd1;
        end else if (w_wr_win) begin
            r_win_len <= writedata;
            r_win_cnt <= writedata - 32'd1;
            r_acc     <= 16'd0;
        end else if (r_win_cnt == 32'd0) begin
            r_velocity <= w_acc_sum;
            r_acc      <= 16'd0;
            r_win_cnt  <= r_win_len - 32'd1;
        end else begin
            r_acc     <= w_acc_sum;
            r_win_cnt <= r_win_cnt - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else if (read) begin
            case (address)
                2'd0:    readdata <= r_position;
                2'd1:    readdata <= {{16{r_velocity[15]}}, r_velocity};
                2'd2:    readdata <= {28'd0, w_filt[0], w_filt[1], r_dir, r_err};
                default: readdata <= r_win_len;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_encoder_if
// Description : Scoreboard bench for quad_encoder_if with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_if;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        enc_a = 1'b1;
    logic        enc_b = 1'b1;

    int          n_vec = 0;
    int          n_err = 0;
    int          idx = 0;
    logic [31:0] q_exp[$];
    string       q_name[$];

    quad_encoder_if #(
        .FILTER_LEN     (4),
        .WINDOW_DEFAULT (500000)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .enc_a     (enc_a),
        .enc_b     (enc_b)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp_val, input string name);
        q_exp.push_back(exp_val);
        q_name.push_back(name);
        address = a;
        read    = 1'b1;
        tick(1);
        read    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick(1);
        write     = 1'b0;
    endtask

    function automatic logic [1:0] gray(input int i);
        case (i & 3)
            0:       gray = 2'b00;
            1:       gray = 2'b01;
            2:       gray = 2'b11;
            default: gray = 2'b10;
        endcase
    endfunction

    task automatic drive_idx();
        {enc_a, enc_b} = gray(idx);
    endtask

    task automatic step(input bit fwd);
        idx = fwd ? idx + 1 : idx + 3;
        drive_idx();
        tick(10);
    endtask

    task automatic check_reset_zero(input string name);
        n_vec++;
        if (readdata !== 32'd0) begin
            n_err++;
            $display("FAIL %s: readdata got %h expected %h", name, readdata, 32'd0);
        end
    endtask

    // Monitor: every accepted read yields readdata one cycle later.
    initial begin
        forever begin
            @(posedge clk);
            if (read && reset_n) begin
                #1;
                n_vec++;
                if (q_exp.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_read: got %h expected nothing queued", readdata);
                end else begin
                    automatic logic [31:0] e = q_exp.pop_front();
                    automatic string       nm = q_name.pop_front();
                    if (readdata !== e) begin
                        n_err++;
                        $display("FAIL %s: got %h expected %h", nm, readdata, e);
                    end
                end
            end
        end
    end

    initial begin
        // Reset with both pins high.
        enc_a = 1'b1; enc_b = 1'b1;
        tick(3);
        check_reset_zero("reset_readdata");
        reset_n = 1'b1;
        tick(20);
        rd(2, 32'h0000_000C, "reset_status_pins11");
        rd(0, 32'd0,         "reset_position");
        rd(1, 32'd0,         "reset_velocity");
        rd(3, 32'd500000,    "reset_window_len");

        // Re-reset from 00 to start the step tests cleanly.
        reset_n = 1'b0;
        idx = 0;
        drive_idx();
        tick(3);
        reset_n = 1'b1;
        tick(20);
        for (int i = 0; i < 8; i++) step(1'b1);
        rd(0, 32'd8,         "fwd8_position");
        rd(2, 32'h0000_0002, "fwd8_status");
        for (int i = 0; i < 3; i++) step(1'b0);
        rd(0, 32'd5,         "rev3_position");
        rd(2, 32'h0000_0008, "rev3_status");

        // Two-cycle glitch on A must be rejected.
        enc_a = 1'b1;
        tick(2);
        enc_a = 1'b0;
        tick(10);
        rd(0, 32'd5,         "glitch_position");
        rd(2, 32'h0000_0008, "glitch_status");

        // Illegal 01 -> 10 transition.
        idx = idx + 2;
        drive_idx();
        tick(10);
        rd(2, 32'h0000_0005, "illegal_status");
        rd(0, 32'd5,         "illegal_position");
        wr(2, 32'd1);
        rd(2, 32'h0000_0004, "err_cleared");

        // Illegal 10 -> 01 landing in the same cycle as the clear write.
        idx = idx + 2;
        drive_idx();
        tick(6);
        wr(2, 32'd1);
        tick(4);
        rd(2, 32'h0000_0009, "illegal_wins_clear");
        wr(2, 32'd1);
        rd(2, 32'h0000_0008, "err_cleared2");

        // Velocity windows.
        wr(3, 32'd1000);
        for (int i = 0; i < 50; i++) step(1'b1);
        tick(600);
        rd(1, 32'd50,        "velocity_fwd50");
        rd(0, 32'd55,        "position_fwd50");
        wr(3, 32'd1000);
        for (int i = 0; i < 50; i++) step(1'b0);
        tick(600);
        rd(1, 32'hFFFF_FFCE, "velocity_rev50");
        rd(0, 32'd5,         "position_rev50");
        rd(3, 32'd1000,      "window_len_1000");

        // Position wrap and zero window write.
        wr(0, 32'h7FFF_FFFF);
        step(1'b1);
        rd(0, 32'h8000_0000, "wrap_positive");
        wr(0, 32'd0);
        step(1'b0);
        rd(0, 32'hFFFF_FFFF, "wrap_negative");
        wr(3, 32'd0);
        rd(3, 32'd1000,      "window_zero_ignored");

        // Read and write to the same address in one cycle returns the old value.
        q_exp.push_back(32'hFFFF_FFFF);
        q_name.push_back("rw_same_cycle_old");
        address   = 2'd0;
        writedata = 32'h0000_1234;
        read      = 1'b1;
        write     = 1'b1;
        tick(1);
        read  = 1'b0;
        write = 1'b0;
        rd(0, 32'h0000_1234, "rw_same_cycle_new");

        // Asynchronous reset mid-operation.
        reset_n = 1'b0;
        #1;
        check_reset_zero("midop_reset_readdata");
        tick(3);
        reset_n = 1'b1;
        tick(20);
        rd(0, 32'd0,         "midop_position");
        rd(1, 32'd0,         "midop_velocity");
        rd(3, 32'd500000,    "midop_window_len");
        rd(2, 32'h0000_0008, "midop_status");

        for (int i = 0; i < 10 && q_exp.size() != 0; i++) tick(1);
        if (q_exp.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending reads expected 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
